// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: op codes and status-flag bit positions.
package alu_pkg;

  // Codes 000-011 keep the legacy 2-bit encoding; bit 2 selects the newer ops.
  localparam logic [2:0] OP_XOR = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  // Bit positions inside the registered flag vector.
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_NEG   = 3;
  localparam int unsigned N_FLAGS    = 4;

  // True for the ops that produce meaningful carry/overflow.
  function automatic logic is_arith(logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_unit.sv
// Purely combinational ALU datapath: eight ops, carry and signed overflow.
module alu_op_unit
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS  = 32,
  parameter int unsigned SH_BITS = $clog2(N_BITS)
) (
  input  logic [2:0]        op,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [N_BITS-1:0] result,
  output logic              carry,
  output logic              ovf
);

  logic              is_sub;
  logic [N_BITS-1:0] b_eff;
  logic [N_BITS:0]   sum;
  logic [SH_BITS-1:0] sh;
  logic              sum_ovf;

  // Shared adder: SUB is a + ~b + 1 so carry out means "no borrow".
  always_comb begin
    is_sub  = (op == OP_SUB);
    b_eff   = is_sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{N_BITS{1'b0}}, is_sub};
    sum_ovf = (a[N_BITS-1] == b_eff[N_BITS-1]) && (sum[N_BITS-1] != a[N_BITS-1]);
    sh      = b[SH_BITS-1:0];
  end

  // Operation select; carry/ovf only survive for ADD and SUB.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      OP_XOR: result = a ^ b;
      OP_ADD: result = sum[N_BITS-1:0];
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SUB: result = sum[N_BITS-1:0];
      OP_SRL: result = a >> sh;
      OP_SRA: result = $unsigned($signed(a) >>> sh);
      OP_NOR: result = ~(a | b);
    endcase
    if (is_arith(op)) begin
      carry = sum[N_BITS];
      ovf   = sum_ovf;
    end
  end

endmodule

// File: rtl/alu_op_pipe.sv
// Two-stage valid/ready pipelined ALU: S1 captures operands, S2 registers result and flags.
module alu_op_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS  = 32,
  parameter int unsigned SH_BITS = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [N_BITS-1:0] in_a,
  input  logic [N_BITS-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_result,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_neg
);

  // Stage 1 operand registers.
  logic              s1_valid_q;
  logic [2:0]        s1_op_q;
  logic [N_BITS-1:0] s1_a_q;
  logic [N_BITS-1:0] s1_b_q;

  // Stage 2 (output) registers.
  logic               out_valid_q;
  logic [N_BITS-1:0]  out_result_q;
  logic [N_FLAGS-1:0] flags_q;
  logic [N_FLAGS-1:0] flags_d;

  logic              s1_en;
  logic              s2_en;
  logic [N_BITS-1:0] alu_result;
  logic              alu_carry;
  logic              alu_ovf;

  // Stage enables: a stage may load when empty or when its successor is draining.
  always_comb begin
    s2_en    = !out_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_ready = s1_en;
  end

  alu_op_unit #(
    .N_BITS  (N_BITS),
    .SH_BITS (SH_BITS)
  ) u_alu (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (alu_result),
    .carry  (alu_carry),
    .ovf    (alu_ovf)
  );

  // Flag vector for the result currently being computed from S1.
  always_comb begin
    flags_d             = '0;
    flags_d[FLAG_ZERO]  = (alu_result == '0);
    flags_d[FLAG_CARRY] = alu_carry;
    flags_d[FLAG_OVF]   = alu_ovf;
    flags_d[FLAG_NEG]   = alu_result[N_BITS-1];
  end

  // Stage 1: capture an accepted beat; a bubble enters when in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q <= in_op;
        s1_a_q  <= in_a;
        s1_b_q  <= in_b;
      end
    end
  end

  // Stage 2: register result and flags; data holds across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      flags_q      <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result_q <= alu_result;
        flags_q      <= flags_d;
      end
    end
  end

  // Output port mapping.
  always_comb begin
    out_valid  = out_valid_q;
    out_result = out_result_q;
    out_zero   = flags_q[FLAG_ZERO];
    out_carry  = flags_q[FLAG_CARRY];
    out_ovf    = flags_q[FLAG_OVF];
    out_neg    = flags_q[FLAG_NEG];
  end

endmodule

// File: doc/alu_op_pipe.md
Name: alu_op_pipe

Overview:
- Parametrised, pipelined successor of the ALU operation selector.
- Computes one of eight operations on two N_BITS operands and registers the result with status flags.
- Uses a valid/ready handshake on input and output and has a fixed 2-cycle latency when not stalled.
- Sits between the operand source (register/switch interface) and the result sink (display/UART/writeback).

Parameters:
- N_BITS, 32, operand/result width; legal range is 4 or more.
- SH_BITS, $clog2(N_BITS), number of low bits of operand b used as the shift amount.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op beat is valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_op  in  3  operation code.
- in_a  in  N_BITS  operand A.
- in_b  in  N_BITS  operand B (low SH_BITS bits give the shift amount).
- out_valid  out  1  result beat is valid.
- out_ready  in  1  sink accepts the result.
- out_result  out  N_BITS  operation result.
- out_zero  out  1  out_result == 0.
- out_carry  out  1  carry out for ADD; NOT borrow for SUB; 0 otherwise.
- out_ovf  out  1  signed overflow for ADD/SUB; 0 otherwise.
- out_neg  out  1  out_result[N_BITS-1].

Behaviour:
- Op codes:
  - 000 XOR
  - 001 ADD
  - 010 AND
  - 011 OR
  - 100 SUB (a-b)
  - 101 SRL (a>>sh)
  - 110 SRA (a>>>sh)
  - 111 NOR
- Codes 000-011 keep the legacy 2-bit encoding when in_op[2]=0.
- Stage 1 (S1):
  - Registers op, a, b and s1_valid on an input handshake (in_valid && in_ready).
- Stage 2 (S2):
  - Computes the op combinationally from the S1 registers.
  - Registers result and flags into the out_* registers, plus out_valid.
- Advance rules:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en (combinational, no combinational path from in_valid).
- Bubbles: when s2_en is true and s1_valid=0, out_valid clears next cycle.
- Latency and throughput:
  - Result appears on out_* exactly 2 cycles after acceptance when out_ready stays high.
  - Throughput is 1 beat/cycle with no bubbles under continuous valid/ready.
- Stall:
  - While out_valid && !out_ready, out_* hold stable.
  - S1 holds if full; in_ready=0 when both stages are full.
  - Holds at most 2 beats in flight; no beat is lost or duplicated.
- Arithmetic:
  - ADD: {carry,result} = a + b in N_BITS+1 bits.
  - SUB: a + ~b + 1; carry=1 means no borrow.
  - ovf = (a_sign == b_eff_sign) && (result_sign != a_sign), with b_eff = b for ADD and ~b for SUB.
  - Shifts use in_b[SH_BITS-1:0] only; a shift of 0 returns a.
  - SRA fills with a[N_BITS-1].
- Flags:
  - zero and neg are valid for all ops.
  - carry and ovf are forced to 0 for non-ADD/SUB ops.
- Reset (asynchronous, active low):
  - s1_valid = 0, out_valid = 0, out_result = 0, all flags = 0.
  - in_ready = 1 immediately after reset release.
  - A mid-operation reset discards all in-flight beats.
- Simultaneous events: accepting into S1 while S2 drains to the sink is a legal same-cycle event and needs no bubble.

Decomposition:
- Package alu_pkg holds:
  - op code localparams: OP_XOR, OP_ADD, OP_AND, OP_OR, OP_SUB, OP_SRL, OP_SRA, OP_NOR;
  - the flag index constants.
- Sub-module alu_op_unit is purely combinational:
  - parametrised N_BITS;
  - inputs op, a, b;
  - outputs result, carry, ovf.
- alu_op_pipe wraps alu_op_unit with the two register stages and the handshake.

Test Plan (N_BITS=8):
- Reset check: assert rst_n=0 mid-stream -> out_valid=0, out_result=0x00, flags 0 asynchronously; in_ready=1 after release.
- ADD overflow: op=001, a=0x7F, b=0x01, out_ready=1 -> 2 cycles later result=0x80, ovf=1, neg=1, carry=0, zero=0.
- ADD/SUB carry and zero: op=001, a=0xFF, b=0x01 -> result=0x00, carry=1, zero=1; then op=100, a=0x03, b=0x05 -> result=0xFE, carry=0, neg=1.
- Shifts: op=110, a=0x90, b=0x03 -> 0xF2; op=101, a=0x90, b=0x0B (sh=3) -> 0x12; op=111, a=0x0F, b=0xF0 -> 0x00, zero=1.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepted; out_* stable; on release, results exit in order with none lost.
- Throughput: random ops for 1000 beats with random valid/ready against a reference model -> in-order, bit-exact results and flags, 1 beat/cycle when both sides are always ready.
